// File: rtl/rv_pipe_pkg.sv
// Shared RV32 pipeline types: packed control bundle and common constants.
package rv_pipe_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       spare;
  } ctrl_t;

  localparam int         CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t      CTRL_NOP = '0;
  localparam logic [4:0] REG_X0   = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX-stage load and the ID-stage reader.
module load_use_detect
  import rv_pipe_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       load_use_o
);

  logic ex_is_load;
  logic rs_match;

  // x0 is never written, so a load into x0 cannot create a dependency.
  assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rd_i != REG_X0);
  assign rs_match   = (id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                      (id_uses_rs2_i & (id_rs2_i == ex_rd_i));
  assign load_use_o = ex_is_load & id_valid_i & rs_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and stall freeze.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = $bits(ctrl_t),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  lu_bubble_cnt,
  output logic [CNT_W-1:0]  flush_bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;
  ctrl_t             ex_ctrl_s;
  logic              load_use;

  assign ex_ctrl_s = ctrl_q;

  load_use_detect u_lu (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ex_ctrl_s.mem_read),
    .ex_rd_i       (rd_q),
    .id_valid_i    (id_valid),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .load_use_o    (load_use)
  );

  // A flush kills the ID instruction anyway, so it must not hold IF/ID.
  assign stall_if_id = mem_stall | (load_use & ~flush);

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    lu_cnt_d   = lu_cnt_q;
    fl_cnt_d   = fl_cnt_q;
    if (!mem_stall) begin
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      if (flush || load_use) begin
        // Bubble: no side effects and rd cleared so forwarding never matches.
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
        rd_d    = REG_X0;
        if (flush) begin
          if (fl_cnt_q != CNT_MAX) fl_cnt_d = fl_cnt_q + 1'b1;
        end else begin
          if (lu_cnt_q != CNT_MAX) lu_cnt_d = lu_cnt_q + 1'b1;
        end
      end else begin
        valid_d = id_valid;
        ctrl_d  = id_valid ? id_ctrl : CTRL_NOP;
        rd_d    = id_valid ? id_rd : REG_X0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      lu_cnt_q   <= '0;
      fl_cnt_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      lu_cnt_q   <= lu_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_pc            = pc_q;
  assign ex_rs1_data      = rs1_data_q;
  assign ex_rs2_data      = rs2_data_q;
  assign ex_imm           = imm_q;
  assign ex_rs1           = rs1_q;
  assign ex_rs2           = rs2_q;
  assign ex_rd            = rd_q;
  assign ex_ctrl          = ctrl_q;
  assign lu_bubble_cnt    = lu_cnt_q;
  assign flush_bubble_cnt = fl_cnt_q;

endmodule
